// File: rtl/audio_tdm_out_serializer.sv
// DAC-side TDM/I2S serializer: a frame FIFO feeding an MSB-first shift register that is
// advanced by BCLK falling-edge pulses and restarted by every LRCLK falling-edge pulse.
module audio_tdm_out_serializer #(
    parameter int DATA_WIDTH          = 24,
    parameter int NUM_CHANNELS        = 2,
    parameter int FIFO_DEPTH          = 128,
    parameter bit I2S_MODE            = 1'b1,
    parameter bit REPEAT_ON_UNDERFLOW = 1'b0,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clear,
    input  logic                                 bit_clk_falling_edge,
    input  logic                                 lrclk_falling_edge,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   sample_data,
    input  logic                                 sample_valid,
    output logic                                 sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_space,
    output logic                                 serial_data_out,
    output logic                                 synced,
    output logic                                 underflow,
    output logic [CNT_WIDTH-1:0]                 underflow_count
);

    localparam int TOTAL = NUM_CHANNELS * DATA_WIDTH;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int AW1   = AW + 1;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam logic [AW:0]   DEPTH_V = AW1'(FIFO_DEPTH);
    localparam logic [CW-1:0] TOTAL_V = CW'(TOTAL);

    typedef enum logic {WAIT_SYNC, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]         occ_q, occ_d, fifo_space_q, fifo_space_d;
    logic [TOTAL-1:0]    shift_q, shift_d, last_q, last_d;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                serial_q, serial_d, synced_q, synced_d, underflow_q, underflow_d;
    logic [CNT_WIDTH-1:0] uf_cnt_q, uf_cnt_d;

    logic [TOTAL-1:0]    mem [FIFO_DEPTH];
    logic [TOTAL-1:0]    head, load_frame, ordered;
    logic                fifo_empty, push, pop;

    assign fifo_empty   = (occ_q == '0);
    assign sample_ready = (occ_q != DEPTH_V);
    assign push         = sample_valid && sample_ready && !clear;
    assign pop          = lrclk_falling_edge && !fifo_empty && !clear;
    assign head         = mem[rd_ptr_q];

    // NOTE: the frame store has no reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= sample_data;
    end

    always_comb begin
        // NOTE: every _d takes its _q value first, so no branch below can infer a latch.
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        shift_d      = shift_q;
        last_d       = last_q;
        bit_cnt_d    = bit_cnt_q;
        serial_d     = serial_q;
        synced_d     = synced_q;
        underflow_d  = underflow_q;
        uf_cnt_d     = uf_cnt_q;

        load_frame = fifo_empty ? (REPEAT_ON_UNDERFLOW ? last_q : '0) : head;
        ordered    = '0;
        // Slot 0 sits in the low bits of a frame but must leave the line first.
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            ordered[TOTAL-1-k*DATA_WIDTH -: DATA_WIDTH] = load_frame[k*DATA_WIDTH +: DATA_WIDTH];
        end

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   occ_d = occ_q + AW1'(1);
            2'b01:   occ_d = occ_q - AW1'(1);
            default: occ_d = occ_q;
        endcase

        if (lrclk_falling_edge) begin
            state_d  = SHIFT;
            synced_d = 1'b1;
            if (!fifo_empty) begin
                last_d = head;
            end else begin
                underflow_d = 1'b1;
                if (uf_cnt_q != {CNT_WIDTH{1'b1}}) uf_cnt_d = uf_cnt_q + CNT_WIDTH'(1);
            end
            if (I2S_MODE) begin
                shift_d   = ordered;
                bit_cnt_d = '0;
                serial_d  = 1'b0;
            end else begin
                shift_d   = ordered << 1;
                bit_cnt_d = CW'(1);
                serial_d  = ordered[TOTAL-1];
            end
        end else if (state_q == SHIFT && bit_clk_falling_edge) begin
            if (bit_cnt_q < TOTAL_V) begin
                serial_d  = shift_q[TOTAL-1];
                shift_d   = shift_q << 1;
                bit_cnt_d = bit_cnt_q + CW'(1);
            end else begin
                serial_d  = 1'b0;
            end
        end

        if (clear) begin
            state_d     = WAIT_SYNC;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            occ_d       = '0;
            shift_d     = '0;
            last_d      = '0;
            bit_cnt_d   = '0;
            serial_d    = 1'b0;
            synced_d    = 1'b0;
            underflow_d = 1'b0;
            uf_cnt_d    = '0;
        end

        fifo_space_d = DEPTH_V - occ_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= WAIT_SYNC;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            fifo_space_q <= DEPTH_V;
            shift_q      <= '0;
            last_q       <= '0;
            bit_cnt_q    <= '0;
            serial_q     <= 1'b0;
            synced_q     <= 1'b0;
            underflow_q  <= 1'b0;
            uf_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            fifo_space_q <= fifo_space_d;
            shift_q      <= shift_d;
            last_q       <= last_d;
            bit_cnt_q    <= bit_cnt_d;
            serial_q     <= serial_d;
            synced_q     <= synced_d;
            underflow_q  <= underflow_d;
            uf_cnt_q     <= uf_cnt_d;
        end
    end

    assign fifo_space      = fifo_space_q;
    assign serial_data_out = serial_q;
    assign synced          = synced_q;
    assign underflow       = underflow_q;
    assign underflow_count = uf_cnt_q;

endmodule

// File: tb/tb_audio_tdm_out_serializer.sv
// Bench: two serializers share every input; dut0 is the I2S/zero-fill build, dut1 the
// left-justified/replay build. Frame vectors come from a table, corner cases are hand sequences.
module tb_audio_tdm_out_serializer;

    logic        clk = 1'b0;
    logic        reset, clear, bclk, lrclk, sample_valid;
    logic [47:0] sample_data;

    logic        rdy0, ser0, syn0, uf0, rdy1, ser1, syn1, uf1;
    logic [7:0]  space0, space1;
    logic [15:0] ufc0, ufc1;

    int n_err = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    audio_tdm_out_serializer dut0 (
        .clk(clk), .reset(reset), .clear(clear),
        .bit_clk_falling_edge(bclk), .lrclk_falling_edge(lrclk),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(rdy0), .fifo_space(space0), .serial_data_out(ser0),
        .synced(syn0), .underflow(uf0), .underflow_count(ufc0)
    );

    audio_tdm_out_serializer #(.I2S_MODE(1'b0), .REPEAT_ON_UNDERFLOW(1'b1)) dut1 (
        .clk(clk), .reset(reset), .clear(clear),
        .bit_clk_falling_edge(bclk), .lrclk_falling_edge(lrclk),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(rdy1), .fifo_space(space1), .serial_data_out(ser1),
        .synced(syn1), .underflow(uf1), .underflow_count(ufc1)
    );

    typedef struct {
        logic [23:0] left;
        logic [23:0] right;
        logic        coinc;   // BCLK pulse coincident with the frame start
        int          nfalls;  // BCLK falls before the next frame start
        logic [63:0] exp_bits;
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r);
        sample_data  = {r, l};
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic frame_start(input logic coinc);
        lrclk = 1'b1;
        bclk  = coinc;
        step();
        lrclk = 1'b0;
        bclk  = 1'b0;
    endtask

    task automatic fall();
        bclk = 1'b1;
        step();
        bclk = 1'b0;
        step();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] cap0, cap1;
        int idx;

        vecs[0] = '{24'hA5A5A5, 24'h5A5A5A, 1'b0, 64, 64'hA5A5A5_5A5A5A_0000};
        vecs[1] = '{24'h800001, 24'h7FFFFF, 1'b1, 10, 64'h800001_7FFFFF_0000};
        vecs[2] = '{24'hFFFFFF, 24'h000000, 1'b0, 64, 64'hFFFFFF_000000_0000};

        reset = 1'b1; clear = 1'b0; bclk = 1'b0; lrclk = 1'b0;
        sample_valid = 1'b0; sample_data = '0;
        #12;
        check("rst_ready",  rdy0,   1);
        check("rst_space",  space0, 128);
        check("rst_serial", ser0,   0);
        check("rst_synced", syn0,   0);
        check("rst_uf",     uf0,    0);
        check("rst_ufcnt",  ufc0,   0);
        check("rst_space1", space1, 128);
        @(posedge clk); #1;
        reset = 1'b0;

        // No frame start: pushes buffer, the line stays quiet.
        for (int i = 0; i < 3; i++) push(24'hFFFFFF, 24'hFFFFFF);
        for (int i = 0; i < 4; i++) begin
            fall();
            check("nosync_ser0", ser0, 0);
            check("nosync_ser1", ser1, 0);
        end
        check("nosync_synced", syn0, 0);
        check("nosync_space",  space0, 125);
        pulse_clear();
        check("clear_space", space0, 128);

        // Table-driven frames.
        foreach (vecs[v]) begin
            push(vecs[v].left, vecs[v].right);
            check($sformatf("v%0d_space_push", v), space0, 127);
            frame_start(vecs[v].coinc);
            check($sformatf("v%0d_space_pop", v), space0, 128);
            check($sformatf("v%0d_start_ser0", v), ser0, 0);
            check($sformatf("v%0d_start_ser1", v), ser1, vecs[v].exp_bits[63]);
            for (int i = 1; i <= vecs[v].nfalls; i++) begin
                fall();
                check($sformatf("v%0d_bit%0d_ser0", v, i), ser0, vecs[v].exp_bits[64-i]);
                idx = 63 - i;
                check($sformatf("v%0d_bit%0d_ser1", v, i), ser1, (idx >= 0) ? vecs[v].exp_bits[idx] : 1'b0);
            end
        end
        check("synced_after", syn0, 1);
        check("uf_none",      uf0,  0);

        // Underflow: three frame starts on an empty FIFO.
        for (int s = 0; s < 3; s++) begin
            cap0 = '0;
            cap1 = '0;
            frame_start(1'b0);
            cap1[63] = ser1;
            for (int i = 1; i <= 64; i++) begin
                fall();
                cap0[64-i] = ser0;
                if (i <= 63) cap1[63-i] = ser1;
            end
            check($sformatf("uf%0d_zeros", s),  cap0, 64'h0);
            check($sformatf("uf%0d_replay", s), cap1, 64'hFFFFFF_000000_0000);
            check($sformatf("uf%0d_cnt0", s),   ufc0, s + 1);
        end
        check("uf_flag0", uf0,  1);
        check("uf_flag1", uf1,  1);
        check("uf_cnt1",  ufc1, 3);

        // Fill, simultaneous push/pop, full, FIFO order.
        pulse_clear();
        check("clr_uf",    uf0,  0);
        check("clr_ufcnt", ufc0, 0);
        check("clr_sync",  syn0, 0);
        for (int i = 0; i < 127; i++) push((i % 2 == 1) ? 24'h800000 : 24'h0, 24'h0);
        check("fill127_space", space0, 1);
        check("fill127_ready", rdy0,   1);
        sample_data  = {24'h0, 24'h800000};
        sample_valid = 1'b1;
        lrclk        = 1'b1;
        step();
        sample_valid = 1'b0;
        lrclk        = 1'b0;
        check("pushpop_space", space0, 1);
        check("pushpop_head",  ser1,   0);
        check("pushpop_uf",    uf1,    0);
        push(24'h0, 24'h0);
        check("full_ready", rdy0,   0);
        check("full_space", space0, 0);
        push(24'hFFFFFF, 24'hFFFFFF);
        check("full_drop_space", space0, 0);
        frame_start(1'b0);
        check("order1_ser1", ser1,   1);
        check("order1_space", space0, 1);
        frame_start(1'b0);
        check("order2_ser1", ser1,   0);
        check("order2_space", space0, 2);

        // Asynchronous reset mid-frame.
        pulse_clear();
        push(24'hFFFFFF, 24'h0);
        frame_start(1'b0);
        fall();
        fall();
        check("pre_rst_ser0", ser0, 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_rst_ser0",  ser0,   0);
        check("async_rst_ser1",  ser1,   0);
        check("async_rst_sync",  syn0,   0);
        check("async_rst_space", space0, 128);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fall();
            check("post_rst_ser0", ser0, 0);
            check("post_rst_ser1", ser1, 0);
        end
        push(24'hFFFFFF, 24'h0);
        frame_start(1'b0);
        check("resume_sync", syn0, 1);
        check("resume_ser1", ser1, 1);
        fall();
        check("resume_ser0", ser0, 1);

        // Synchronous clear mid-frame with a coincident push that must be dropped.
        fall();
        clear        = 1'b1;
        sample_data  = {24'h0, 24'hFFFFFF};
        sample_valid = 1'b1;
        step();
        clear        = 1'b0;
        sample_valid = 1'b0;
        check("clr_mid_ser0",  ser0,   0);
        check("clr_mid_ser1",  ser1,   0);
        check("clr_mid_sync",  syn0,   0);
        check("clr_mid_space", space0, 128);
        for (int i = 0; i < 2; i++) begin
            fall();
            check("post_clr_ser0", ser0, 0);
            check("post_clr_ser1", ser1, 0);
        end
        push(24'hFFFFFF, 24'h0);
        frame_start(1'b0);
        check("clr_resume_sync", syn0, 1);
        check("clr_resume_ser1", ser1, 1);
        check("clr_resume_uf",   uf0,  0);
        fall();
        check("clr_resume_ser0", ser0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
